muldiv_sequencer: RTL and testbench

//  Sequencer for the shared iterative multiply/divide resource and the HI/LO register pair.

---
 rtl/muldiv_sequencer_pkg.sv | 30 +++
 rtl/muldiv_sequencer_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// muldiv_sequencer_pkg: shared op encoding and sequencer state codes.
// Rev 1.0
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_RUN  = 2'd1;
  localparam muldiv_state_t ST_FIX  = 2'd2;

  function automatic logic is_signed_op(input muldiv_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
`default_nettype none
// muldiv_step: one combinational shift-add (MUL) or restoring shift-subtract (DIV) iteration.
// Rev 1.0
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] low_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] trial;

  always_comb begin
    mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    trial    = {acc, low[WIDTH-1]} - {1'b0, operand};
    acc_next = mul_sum[WIDTH:1];
    low_next = {mul_sum[0], low[WIDTH-1:1]};
    if (is_div) begin
      // The partial remainder is always below the divisor, so W+1 bits hold the trial.
      if (!trial[WIDTH]) begin
        acc_next = trial[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[WIDTH-2:0], low[WIDTH-1]};
        low_next = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// muldiv_sequencer: iterative MULT/DIV sequencer owning the HI/LO pair, with stall request.
// Rev 1.0
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiLoRead,
  input  logic             flush,
  output logic             busy,
  output logic             stallRequest,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] raw_a;
  logic             is_div;
  logic             neg_result;
  logic             neg_rem;
  logic             div_zero;
  logic             done_q;

  muldiv_op_t       op_sel;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] low_next;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fixed;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign op_sel = muldiv_op_t'(op);
  assign sign_a = is_signed_op(op_sel) & operandA[WIDTH-1];
  assign sign_b = is_signed_op(op_sel) & operandB[WIDTH-1];
  assign abs_a  = sign_a ? (~operandA + 1'b1) : operandA;
  assign abs_b  = sign_b ? (~operandB + 1'b1) : operandB;

  assign busy         = (state != ST_IDLE);
  assign stallRequest = (start || hiLoRead) && busy;
  assign done         = done_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .low      (low),
    .operand  (operand),
    .acc_next (acc_next),
    .low_next (low_next)
  );

  always_comb begin
    product       = {acc, low};
    product_fixed = neg_result ? (~product + 1'b1) : product;
    fix_hi        = product_fixed[2*WIDTH-1:WIDTH];
    fix_lo        = product_fixed[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = raw_a;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = neg_rem    ? (~acc + 1'b1) : acc;
        fix_lo = neg_result ? (~low + 1'b1) : low;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      acc        <= '0;
      low        <= '0;
      operand    <= '0;
      raw_a      <= '0;
      is_div     <= 1'b0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      done_q     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              case (op_sel)
                OP_MTHI: hi <= operandA;
                OP_MTLO: lo <= operandA;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  // Multiplier (MUL) or dividend (DIV) shifts through the low register.
                  acc        <= '0;
                  low        <= is_div_op(op_sel) ? abs_a : abs_b;
                  operand    <= is_div_op(op_sel) ? abs_b : abs_a;
                  raw_a      <= operandA;
                  is_div     <= is_div_op(op_sel);
                  neg_result <= sign_a ^ sign_b;
                  neg_rem    <= sign_a;
                  div_zero   <= is_div_op(op_sel) && (operandB == '0);
                  count      <= CW'(WIDTH - 1);
                  state      <= ST_RUN;
                end
                default: ;
              endcase
            end
          end
          ST_RUN: begin
            acc   <= acc_next;
            low   <= low_next;
            count <= count - 1'b1;
            if (count == '0) state <= ST_FIX;
          end
          ST_FIX: begin
            hi     <= fix_hi;
            lo     <= fix_lo;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// tb_muldiv_sequencer: self-checking bench with a 64-bit arithmetic reference model.
// Rev 1.0
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, hiLoRead, flush;
  logic [2:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, stallRequest, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .operandA     (operandA),
    .operandB     (operandB),
    .hiLoRead     (hiLoRead),
    .flush        (flush),
    .busy         (busy),
    .stallRequest (stallRequest),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      OP_MULT:  begin q = sa * sb; p = q; end
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIVU:  if (b == 0) p = {a, 32'hFFFF_FFFF}; else p = {a % b, a / b};
      OP_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic exec_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output logic early_done,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output logic rdone, output logic rdone_next);
    op = o; operandA = a; operandB = b; start = 1'b1;
    tick();
    start = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    busy_cycles = 0;
    early_done  = 1'b0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (done === 1'b1) early_done = 1'b1;
      tick();
    end
    rhi = hi; rlo = lo; rdone = done;
    tick();
    rdone_next = done;
  endtask

  task automatic write_hilo(input logic [2:0] o, input logic [31:0] v);
    op = o; operandA = v; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; hiLoRead = 1'b0; flush = 1'b0;
    op = OP_MULTU; operandA = '0; operandB = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if ({busy, stallRequest, done} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: busy/stall/done=%b%b%b hi=%h lo=%h, required 000 hi=0 lo=0",
               busy, stallRequest, done, hi, lo);
    end
  endtask

  task automatic test_multu_basic();
    int bc; logic ed, d, dn; logic [31:0] rh, rl;
    exec_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (bc != 33) begin n_bad++; $display("FAIL multu_latency: busy %0d cycles, required 33", bc); end
    n_cmp++;
    if (rh !== 32'h1 || rl !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL multu_result: hi=%h lo=%h, required 00000001 fffffffe", rh, rl);
    end
    n_cmp++;
    if ({ed, d, dn} !== 3'b010) begin
      n_bad++; $display("FAIL multu_done_pulse: early/done/next=%b%b%b, required 010", ed, d, dn);
    end
  endtask

  task automatic test_div_signed();
    int bc; logic ed, d, dn; logic [31:0] rh, rl;
    exec_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL div_neg7_by_2: hi=%h lo=%h, required ffffffff fffffffd", rh, rl);
    end
    exec_op(OP_DIVU, 32'd7, 32'd0, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (rl !== 32'hFFFF_FFFF || rh !== 32'd7 || bc != 33 || d !== 1'b1) begin
      n_bad++; $display("FAIL divu_by_zero: hi=%h lo=%h busy=%0d done=%b, required 7 ffffffff 33 1", rh, rl, bc, d);
    end
    exec_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (rl !== 32'hFFFF_FFFF || rh !== 32'hFFFF_FFF0) begin
      n_bad++; $display("FAIL div_neg_by_zero: hi=%h lo=%h, required fffffff0 ffffffff", rh, rl);
    end
  endtask

  task automatic test_boundary();
    int bc; logic ed, d, dn; logic [31:0] rh, rl;
    exec_op(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (rh !== 32'd0 || rl !== 32'h8000_0000) begin
      n_bad++; $display("FAIL mult_min_by_neg1: hi=%h lo=%h, required 00000000 80000000", rh, rl);
    end
    exec_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, ed, rh, rl, d, dn);
    n_cmp++;
    if (rh !== 32'd0 || rl !== 32'h8000_0000) begin
      n_bad++; $display("FAIL div_min_by_neg1: hi=%h lo=%h, required 00000000 80000000", rh, rl);
    end
  endtask

  task automatic test_random();
    int bc; logic ed, d, dn; logic [31:0] rh, rl, a, b; logic [2:0] o; logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      exp = model(o, a, b);
      exec_op(o, a, b, bc, ed, rh, rl, d, dn);
      n_cmp++;
      if ({rh, rl} !== exp || bc != 33 || d !== 1'b1 || ed !== 1'b0) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h busy=%0d done=%b, required hi=%h lo=%h busy=33 done=1",
                 i, o, a, b, rh, rl, bc, d, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc, stall_bad; logic [31:0] a1, b1, a2, b2; logic [63:0] e1, e2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    e1 = model(OP_MULT, a1, b1);
    e2 = model(OP_DIVU, a2, b2);
    op = OP_MULT; operandA = a1; operandB = b1; start = 1'b1;
    tick();
    op = OP_DIVU; operandA = a2; operandB = b2; hiLoRead = 1'b1;
    bc = 0; stall_bad = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      if (stallRequest !== 1'b1) stall_bad++;
      tick();
    end
    n_cmp++;
    if (stall_bad != 0 || bc != 33) begin
      n_bad++; $display("FAIL stall_while_busy: %0d non-stall cycles over %0d busy, required 0 over 33", stall_bad, bc);
    end
    n_cmp++;
    if ({hi, lo} !== e1 || done !== 1'b1 || stallRequest !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first: hi=%h lo=%h done=%b stall=%b, required %h %h 1 0",
                        hi, lo, done, stallRequest, e1[63:32], e1[31:0]);
    end
    hiLoRead = 1'b0;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin bc++; tick(); end
    n_cmp++;
    if ({hi, lo} !== e2 || bc != 33 || done !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second: hi=%h lo=%h busy=%0d done=%b, required %h %h 33 1",
                        hi, lo, bc, done, e2[63:32], e2[31:0]);
    end
  endtask

  task automatic test_flush();
    logic seen_done;
    write_hilo(OP_MTHI, 32'h11);
    write_hilo(OP_MTLO, 32'h22);
    op = OP_DIV; operandA = $urandom; operandB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++; $display("FAIL flush_run: busy=%b hi=%h lo=%h, required 0 11 22", busy, hi, lo);
    end
    seen_done = 1'b0;
    repeat (40) begin if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1; tick(); end
    n_cmp++;
    if (seen_done !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++; $display("FAIL flush_after: done/busy seen=%b hi=%h lo=%h, required 0 11 22", seen_done, hi, lo);
    end
    op = OP_MULTU; operandA = 32'd5; operandB = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_with_start: busy=%b, required 0", busy); end
    op = OP_MULTU; operandA = 32'd9; operandB = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL fix_cycle_busy: busy=%b, required 1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_bad++; $display("FAIL flush_in_fix: busy=%b done=%b hi=%h lo=%h, required 0 0 11 22", busy, done, hi, lo);
    end
  endtask

  task automatic test_mtlo_and_reset();
    write_hilo(OP_MTLO, 32'h1234);
    hiLoRead = 1'b1;
    #1;
    n_cmp++;
    if (lo !== 32'h1234 || stallRequest !== 1'b0) begin
      n_bad++; $display("FAIL mtlo_read: lo=%h stall=%b, required 1234 0", lo, stallRequest);
    end
    tick();
    hiLoRead = 1'b0;
    write_hilo(OP_MTHI, 32'hABCD);
    n_cmp++;
    if (hi !== 32'hABCD || busy !== 1'b0) begin
      n_bad++; $display("FAIL mthi_write: hi=%h busy=%b, required abcd 0", hi, busy);
    end
    op = OP_DIV; operandA = 32'd1000; operandB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_multu_basic();
    test_div_signed();
    test_boundary();
    test_random();
    test_back_to_back();
    test_flush();
    test_mtlo_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
